// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : PS/2 keyboard serial receiver and scan-code decoder producing a
//                toggle-strobed {toggle, pressed, extended, code} key bus.
//                Optional macro PS2_REPEAT_FILTER_EN drops typematic repeats.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int c_FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FLT_W-1:0] c_FLT_MAX = c_FLT_W'(FILTER_LEN - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic               r_clk_flt;
    logic [c_FLT_W-1:0] r_flt_cnt;
    logic               w_bit_edge;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bitcnt;
    logic               r_par_ok;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_valid_nxt, w_err_nxt;
    logic               r_byte_valid, r_frame_err;

    logic               r_ext, r_brk;
    logic [2:0]         r_skip;
    logic [10:0]        r_key;
    logic               w_is_prefix, w_is_ignore, w_is_event, w_suppress;

    assign ps2_key   = r_key;
    assign frame_err = r_frame_err;

    // Lines idle high, so synchronisers and filter reset to 1.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_flt <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FLT_MAX) begin
                r_clk_flt <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + c_FLT_W'(1);
            end
        end
    end

    // Edge is flagged on the cycle the filtered clock commits to 0.
    assign w_bit_edge = r_clk_flt & ~r_clk_s2 & (r_flt_cnt == c_FLT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_bit_edge && !r_dat_s2) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_edge && (r_bitcnt == 3'd7)) w_state_nxt = S_PARITY;
            end
            S_PARITY: begin
                if (w_bit_edge) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_edge) begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_s2 && r_par_ok) w_valid_nxt = 1'b1;
                    else                      w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && !w_bit_edge && (r_tmo_cnt == c_TMO_MAX)) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_par_ok     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_valid <= w_valid_nxt;
            r_frame_err  <= w_err_nxt;
            if ((r_state == S_IDLE) || w_bit_edge) r_tmo_cnt <= '0;
            else                                   r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            if (w_bit_edge) begin
                case (r_state)
                    S_IDLE:   r_bitcnt <= '0;
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_par_ok <= ^{r_shift, r_dat_s2};
                    default: ;
                endcase
            end
        end
    end

    assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0) || (r_shift == 8'hE1);
    assign w_is_ignore = !r_ext && !r_brk &&
                         ((r_shift == 8'hAA) || (r_shift == 8'hFA) ||
                          (r_shift == 8'hEE) || (r_shift == 8'hFE));
    assign w_is_event  = r_byte_valid && (r_skip == 3'd0) && !w_is_prefix && !w_is_ignore;

`ifdef PS2_REPEAT_FILTER_EN
    logic [8:0] r_last_make;
    logic       r_last_vld;

    assign w_suppress = !r_brk && r_last_vld && ({r_ext, r_shift} == r_last_make);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_last_make <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_is_event) begin
            if (!r_brk) begin
                r_last_make <= {r_ext, r_shift};
                r_last_vld  <= 1'b1;
            end else if ({r_ext, r_shift} == r_last_make) begin
                r_last_vld  <= 1'b0;
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    // A failed frame flushes prefix state so no half-prefixed event escapes.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
            r_key  <= '0;
        end else if (r_frame_err) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (r_byte_valid) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_shift == 8'hE1) begin
                r_skip <= 3'd7;
            end else if (!w_is_ignore) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (!w_suppress) r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Directed self-checking bench for ps2_key_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int c_TMO = 400;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int n_tog = 0;
    int err_pulses = 0;
    int err_hi = 0;
    logic prev_tog = 1'b0;
    logic prev_err = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (ps2_key[10] !== prev_tog) n_tog++;
        prev_tog = ps2_key[10];
        if (frame_err) err_hi++;
        if (frame_err && !prev_err) err_pulses++;
        prev_err = frame_err;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ flip_par);
        ps2_bit(1'b1);
        cyc(20);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(5);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'h0);
        rst_sys_n = 1'b1;
        cyc(5);

        // Lone clock pulse with data high: no frame, no error
        ps2_bit(1'b1);
        cyc(20);
        check("idle_high_err", 32'(err_pulses), 32'd0);

        send_byte(8'h1C, 1'b0);
        check("make_1c", 32'(ps2_key), 32'h61C);
        check("make_1c_err", 32'(err_pulses), 32'd0);

        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("break_1c", 32'(ps2_key), 32'h01C);
        check("break_1c_tog", 32'(n_tog), 32'd2);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_make_75", 32'(ps2_key), 32'h775);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_break_75", 32'(ps2_key), 32'h175);
        check("ext_tog", 32'(n_tog), 32'd4);

        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        check("pause_key", 32'(ps2_key), 32'h175);
        check("pause_tog", 32'(n_tog), 32'd4);
        send_byte(8'h16, 1'b0);
        check("after_pause", 32'(ps2_key), 32'h616);

        send_byte(8'h29, 1'b1);
        check("parity_err", 32'(err_pulses), 32'd1);
        check("parity_key", 32'(ps2_key), 32'h616);
        send_byte(8'h29, 1'b0);
        check("good_29", 32'(ps2_key), 32'h229);
        check("good_29_tog", 32'(n_tog), 32'd6);

        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        cyc(c_TMO + 100);
        check("timeout_err", 32'(err_pulses), 32'd2);
        send_byte(8'h5A, 1'b0);
        check("after_tmo", 32'(ps2_key), 32'h65A);
        check("err_width", 32'(err_hi), 32'(err_pulses));

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_sys_n = 1'b0;
        cyc(3);
        check("midreset_key", 32'(ps2_key), 32'h000);
        check("midreset_err", 32'(frame_err), 32'h0);
        rst_sys_n = 1'b1;
        cyc(c_TMO + 100);
        check("postreset_err", 32'(err_pulses), 32'd2);
        send_byte(8'h5A, 1'b0);
        check("postreset_5a", 32'(ps2_key), 32'h65A);

        cyc(2);
        n_tog = 0;
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
        check("repeat_tog", 32'(n_tog), 32'd3);
`else
        check("repeat_tog", 32'(n_tog), 32'd5);
`endif
        check("repeat_key", 32'(ps2_key), 32'h21C);
        check("final_err", 32'(err_pulses), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
